// File: rtl/dac_data_serializer_pkg.sv
// Shared types and helpers for the DAC word-to-bit-pair serializer.
package dac_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } dac_ser_state_t;

    localparam int UFL_CNT_W = 16;

    // Two bits leave the serializer per clock, so a word spans width/2 beats.
    function automatic int beats(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/dac_data_serializer_if.sv
// Sample-word stream into the serializer.
// Handshake: a word transfers on a rising tx_clk edge where s_valid & s_ready;
// s_data is held stable by the master while s_valid is high and not yet accepted.
interface dac_data_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_data_serializer.sv
// Serializes DAC sample words into rising/falling bit pairs with a word-aligned
// frame marker, idle-pattern insertion and a saturating underflow counter.
module dac_data_serializer
    import dac_ser_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter bit                    MSB_FIRST    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0
) (
    input  logic                       tx_clk,
    input  logic                       tx_rstn,
    input  logic                       enable,
    dac_data_serializer_if.slave       s_if,
    output logic                       tx_data_m,
    output logic                       tx_data_p,
    output logic                       tx_frame,
    output logic [UFL_CNT_W-1:0]       ufl_cnt,
    input  logic                       ufl_clr,
    output dac_ser_state_t             dbg_state
);

    localparam int BEATS = beats(DATA_WIDTH);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_width
        $error("dac_data_serializer: DATA_WIDTH must be even and >= 4");
    end

    dac_ser_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sh_q, sh_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic                    frame_q, frame_d;
    logic [UFL_CNT_W-1:0]    ufl_q, ufl_d;

    logic                    boundary;
    logic                    load;
    logic                    ready;
    logic                    accept;
    logic                    ufl_inc;
    logic [DATA_WIDTH-1:0]   sh_shifted;

    // Send order decides which end of the shifter feeds the output pins.
    if (MSB_FIRST) begin : g_msb
        assign sh_shifted = {sh_q[DATA_WIDTH-3:0], 2'b00};
        assign tx_data_m  = sh_q[DATA_WIDTH-1];
        assign tx_data_p  = sh_q[DATA_WIDTH-2];
    end else begin : g_lsb
        assign sh_shifted = {2'b00, sh_q[DATA_WIDTH-1:2]};
        assign tx_data_m  = sh_q[0];
        assign tx_data_p  = sh_q[1];
    end

    always_comb begin
        boundary     = (cnt_q == LAST_BEAT);
        cnt_d        = boundary ? '0 : cnt_q + CNT_W'(1);
        frame_d      = boundary;
        load         = boundary & ((state_q == RUN) | ((state_q == PRIME) & hold_valid_q));
        ready        = enable & (state_q != IDLE) & (~hold_valid_q | load);
        accept       = s_if.s_valid & ready;

        state_d      = state_q;
        sh_d         = boundary ? IDLE_PATTERN : sh_shifted;
        hold_d       = accept ? s_if.s_data : hold_q;
        hold_valid_d = (hold_valid_q & ~load) | accept;
        ufl_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                hold_valid_d = 1'b0;
                if (enable) state_d = PRIME;
            end
            PRIME: begin
                if (!enable) begin
                    state_d      = IDLE;
                    hold_valid_d = 1'b0;
                end else if (load) begin
                    sh_d    = hold_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A disabled boundary ends the stream; a held word is dropped, not counted.
                if (boundary) begin
                    if (!enable) begin
                        state_d      = IDLE;
                        hold_valid_d = 1'b0;
                    end else if (hold_valid_q) begin
                        sh_d = hold_q;
                    end else begin
                        ufl_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ufl_clr)
            ufl_d = '0;
        else if (ufl_inc && (ufl_q != '1))
            ufl_d = ufl_q + UFL_CNT_W'(1);
        else
            ufl_d = ufl_q;
    end

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            state_q      <= IDLE;
            cnt_q        <= LAST_BEAT;
            sh_q         <= IDLE_PATTERN;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            frame_q      <= 1'b0;
            ufl_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            frame_q      <= frame_d;
            ufl_q        <= ufl_d;
        end
    end

    assign s_if.s_ready = ready;
    assign tx_frame     = frame_q;
    assign ufl_cnt      = ufl_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dac_data_serializer.sv
// Directed bench for dac_data_serializer: MSB-first instance for the main
// scenarios, LSB-first instance for send order.
module tb_dac_data_serializer;
    import dac_ser_pkg::*;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b0;
    logic en2 = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dac_data_serializer_if #(.DATA_WIDTH(W)) s_if ();
    dac_data_serializer_if #(.DATA_WIDTH(W)) s_if2 ();

    logic m, p, fr, m2, p2, fr2;
    logic [15:0] ufl, ufl2;
    dac_ser_state_t st, st2;

    dac_data_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1), .IDLE_PATTERN(16'h0000)) dut (
        .tx_clk(clk), .tx_rstn(rstn), .enable(en), .s_if(s_if),
        .tx_data_m(m), .tx_data_p(p), .tx_frame(fr),
        .ufl_cnt(ufl), .ufl_clr(clr), .dbg_state(st)
    );

    dac_data_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0), .IDLE_PATTERN(16'h0000)) dut2 (
        .tx_clk(clk), .tx_rstn(rstn), .enable(en2), .s_if(s_if2),
        .tx_data_m(m2), .tx_data_p(p2), .tx_frame(fr2),
        .ufl_cnt(ufl2), .ufl_clr(1'b0), .dbg_state(st2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [W-1:0] d, input bit drop);
        s_if.s_data  = d;
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (s_if.s_ready) begin
                @(posedge clk);
                @(negedge clk);
                if (drop) s_if.s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("send_timeout", 32'd0, 32'd1);
        s_if.s_valid = 1'b0;
    endtask

    // Waits for the next frame, then gathers eight MSB-first pairs.
    task automatic grab_word(output logic [W-1:0] w, output int start, output int rdy);
        w = '0;
        start = -1;
        rdy = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (fr) begin
                start = cyc;
                break;
            end
        end
        if (start < 0) begin
            check("frame_timeout", 32'd0, 32'd1);
            return;
        end
        for (int b = 0; b < 8; b++) begin
            if (b > 0) @(negedge clk);
            w = {w[W-3:0], m, p};
            if (s_if.s_ready) rdy++;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] w, exp_w;
    int start, prev_start, rdy;
    logic [15:0] ufl_snap;
    bit seen;

    initial begin
        s_if.s_valid = 1'b0;  s_if.s_data = '0;
        s_if2.s_valid = 1'b0; s_if2.s_data = '0;

        // reset state
        #12;
        check("rst_m", {31'd0, m}, 32'd0);
        check("rst_p", {31'd0, p}, 32'd0);
        check("rst_frame", {31'd0, fr}, 32'd0);
        check("rst_ready", {31'd0, s_if.s_ready}, 32'd0);
        check("rst_ufl", {16'd0, ufl}, 32'd0);
        check("rst_state", {30'd0, st}, {30'd0, IDLE});
        check("rst_state2", {30'd0, st2}, {30'd0, IDLE});

        // single word then one underflow
        @(negedge clk);
        rstn = 1'b1;
        en = 1'b1;
        send_word(16'hA5C3, 1'b1);
        grab_word(w, start, rdy);
        check("word_a5c3", {16'd0, w}, 32'h0000A5C3);
        check("state_run", {30'd0, st}, {30'd0, RUN});
        grab_word(w, start, rdy);
        check("ufl_word_idle", {16'd0, w}, 32'd0);
        check("ufl_one", {16'd0, ufl}, 32'd1);

        // continuous stream 1..16
        repeat (2) @(negedge clk);
        send_word(16'h0001, 1'b0);
        ufl_snap = ufl;
        for (int k = 1; k <= 16; k++) exp_q.push_back(W'(k));
        fork
            begin
                for (int k = 2; k <= 16; k++) send_word(W'(k), 1'b0);
                s_if.s_valid = 1'b0;
            end
            begin
                prev_start = 0;
                for (int k = 1; k <= 16; k++) begin
                    grab_word(w, start, rdy);
                    exp_w = exp_q.pop_front();
                    check($sformatf("stream_w%0d", k), {16'd0, w}, {16'd0, exp_w});
                    if (k > 1) check($sformatf("stream_gap%0d", k), start - prev_start, 32'd8);
                    if (k < 16) check($sformatf("stream_rdy%0d", k), rdy, 32'd1);
                    prev_start = start;
                end
            end
        join
        check("stream_ufl", {16'd0, ufl}, {16'd0, ufl_snap});

        // clear on the same edge as an underflow: clear wins
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_wins", {16'd0, ufl}, 32'd0);

        // enable drops at beat 3 with a word held
        @(negedge clk);
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b1);
        ufl_snap = ufl;
        check("x_frame", {31'd0, fr}, 32'd1);
        w = '0;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) @(negedge clk);
            w = {w[W-3:0], m, p};
            if (b == 3) en = 1'b0;
        end
        check("x_complete", {16'd0, w}, 32'h00001234);
        check("drop_ready", {31'd0, s_if.s_ready}, 32'd0);
        grab_word(w, start, rdy);
        check("held_dropped", {16'd0, w}, 32'd0);
        check("drop_state", {30'd0, st}, {30'd0, IDLE});
        check("drop_ufl", {16'd0, ufl}, {16'd0, ufl_snap});
        check("drop_ready2", {31'd0, s_if.s_ready}, 32'd0);

        // reset at beat 4 of a word
        en = 1'b1;
        send_word(16'hBEEF, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (fr) begin
                seen = 1'b1;
                break;
            end
        end
        check("beef_frame_seen", {31'd0, seen}, 32'd1);
        repeat (4) @(negedge clk);
        check("beef_beat4", {30'd0, m, p}, 32'd3);
        rstn = 1'b0;
        #1;
        check("mid_rst_pair", {30'd0, m, p}, 32'd0);
        check("mid_rst_frame", {31'd0, fr}, 32'd0);
        check("mid_rst_ready", {31'd0, s_if.s_ready}, 32'd0);
        check("mid_rst_state", {30'd0, st}, {30'd0, IDLE});
        @(negedge clk);
        rstn = 1'b1;
        send_word(16'hC0DE, 1'b1);
        grab_word(w, start, rdy);
        check("after_rst_word", {16'd0, w}, 32'h0000C0DE);

        // LSB-first instance
        en2 = 1'b1;
        s_if2.s_data = 16'h0003;
        s_if2.s_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (s_if2.s_ready) begin
                @(posedge clk);
                @(negedge clk);
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        s_if2.s_valid = 1'b0;
        check("lsb_accept", {31'd0, seen}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (fr2) begin
                seen = 1'b1;
                break;
            end
        end
        check("lsb_frame_seen", {31'd0, seen}, 32'd1);
        check("lsb_first_pair", {30'd0, m2, p2}, 32'd3);
        w = '0;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) @(negedge clk);
            w[2*b]   = m2;
            w[2*b+1] = p2;
        end
        check("lsb_word", {16'd0, w}, 32'h00000003);
        check("lsb_ufl", {16'd0, ufl2}, 32'd0);

        // saturation from 0xFFFE
        @(negedge clk);
        force dut.ufl_q = 16'hFFFE;
        #1;
        release dut.ufl_q;
        #1;
        check("ufl_preset", {16'd0, ufl}, 32'h0000FFFE);
        repeat (24) @(negedge clk);
        check("ufl_saturate", {16'd0, ufl}, 32'h0000FFFF);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ufl_clear", {16'd0, ufl}, 32'd0);
        grab_word(w, start, rdy);
        check("ufl_resume_word", {16'd0, w}, 32'd0);
        check("ufl_resume", {16'd0, ufl}, 32'd1);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
